// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_phase_scheduler
//  Description : Phase controller for a two-way intersection (NS / EW lamp
//                sets plus a shared pedestrian walk phase). Owns green
//                allocation, phase timing, all-red clearance and pedestrian
//                service. Every hand-off passes through yellow then all-red.
//  Options     : TLC_NIGHT_FLASH_EN - adds night_flash input and the FLASH
//                phase (both yellows blinking).
//  Revision    : 1.0 - initial release
// ============================================================================
module intersection_phase_scheduler #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 5,
    parameter int CNT_W        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic       night_flash,
`endif
    output logic       ped_ack,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    // Phase encoding (also exported on the phase port)
    localparam logic [2:0] c_ns_g  = 3'd0;
    localparam logic [2:0] c_ns_y  = 3'd1;
    localparam logic [2:0] c_ar_a  = 3'd2;
    localparam logic [2:0] c_ew_g  = 3'd3;
    localparam logic [2:0] c_ew_y  = 3'd4;
    localparam logic [2:0] c_ar_b  = 3'd5;
    localparam logic [2:0] c_walk  = 3'd6;
    localparam logic [2:0] c_flash = 3'd7;

    // Timer reload values: a state lasts DURATION cycles, leaving on timer==0
    localparam logic [CNT_W-1:0] c_green_ld  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] c_yellow_ld = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] c_allred_ld = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] c_walk_ld   = CNT_W'(WALK_TICKS - 1);

    logic [2:0]       r_phase;
    logic [CNT_W-1:0] r_timer;
    logic             r_last_ew;      // 1: last green was EW, 0: NS
    logic             r_ped_pending;
    logic             r_ped_ack;
    logic             r_ns_red, r_ns_yellow, r_ns_green;
    logic             r_ew_red, r_ew_yellow, r_ew_green;
    logic             r_walk;

    logic [2:0]       w_next_phase;
    logic [CNT_W-1:0] w_next_timer;
    logic             w_timer_zero;
    logic             w_enter_walk;
    logic             w_blink_lit;    // yellow state shown while in FLASH

`ifdef TLC_NIGHT_FLASH_EN
    logic             r_blink;
    logic             w_next_blink;
`endif

    assign w_timer_zero = (r_timer == '0);
    assign w_enter_walk = (w_next_phase == c_walk) && (r_phase != c_walk);

    // Next-phase and timer reload selection; transitions only on timer==0
    always_comb begin
        w_next_phase = r_phase;
        w_next_timer = r_timer - 1'b1;
`ifdef TLC_NIGHT_FLASH_EN
        w_next_blink = r_blink;
`endif
        if (w_timer_zero) begin
            case (r_phase)
                c_ns_g: begin
                    if (ew_car || r_ped_pending) begin
                        w_next_phase = c_ns_y;
                        w_next_timer = c_yellow_ld;
                    end else begin
                        w_next_timer = c_green_ld;
                    end
                end
                c_ns_y: begin
                    w_next_phase = c_ar_a;
                    w_next_timer = c_allred_ld;
                end
                c_ar_a: begin
                    if (r_ped_pending) begin
                        w_next_phase = c_walk;
                        w_next_timer = c_walk_ld;
                    end else begin
                        w_next_phase = c_ew_g;
                        w_next_timer = c_green_ld;
                    end
`ifdef TLC_NIGHT_FLASH_EN
                    if (night_flash) begin
                        w_next_phase = c_flash;
                        w_next_timer = c_yellow_ld;
                        w_next_blink = 1'b1;
                    end
`endif
                end
                c_ew_g: begin
                    if (ns_car || r_ped_pending) begin
                        w_next_phase = c_ew_y;
                        w_next_timer = c_yellow_ld;
                    end else begin
                        w_next_timer = c_green_ld;
                    end
                end
                c_ew_y: begin
                    w_next_phase = c_ar_b;
                    w_next_timer = c_allred_ld;
                end
                c_ar_b: begin
                    if (r_ped_pending) begin
                        w_next_phase = c_walk;
                        w_next_timer = c_walk_ld;
                    end else begin
                        w_next_phase = c_ns_g;
                        w_next_timer = c_green_ld;
                    end
`ifdef TLC_NIGHT_FLASH_EN
                    if (night_flash) begin
                        w_next_phase = c_flash;
                        w_next_timer = c_yellow_ld;
                        w_next_blink = 1'b1;
                    end
`endif
                end
                c_walk: begin
                    w_next_phase = r_last_ew ? c_ns_g : c_ew_g;
                    w_next_timer = c_green_ld;
                end
                c_flash: begin
`ifdef TLC_NIGHT_FLASH_EN
                    if (night_flash) begin
                        w_next_timer = c_yellow_ld;
                        w_next_blink = ~r_blink;
                    end else begin
                        w_next_phase = c_ar_b;
                        w_next_timer = c_allred_ld;
                    end
`else
                    // Unreachable without the night-flash option; recover safely
                    w_next_phase = c_ar_b;
                    w_next_timer = c_allred_ld;
`endif
                end
                default: begin
                    w_next_phase = c_ar_b;
                    w_next_timer = c_allred_ld;
                end
            endcase
        end
    end

`ifdef TLC_NIGHT_FLASH_EN
    assign w_blink_lit = w_next_blink;
`else
    assign w_blink_lit = 1'b0;
`endif

    // Phase, timer, last-green and pedestrian bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase       <= c_ar_b;
            r_timer       <= c_allred_ld;
            r_last_ew     <= 1'b1;
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_phase       <= w_next_phase;
            r_timer       <= w_next_timer;
            if (w_next_phase == c_ns_g) begin
                r_last_ew <= 1'b0;
            end else if (w_next_phase == c_ew_g) begin
                r_last_ew <= 1'b1;
            end
            // Entering WALK serves the request and swallows a same-cycle press
            r_ped_pending <= w_enter_walk ? 1'b0 : (r_ped_pending | ped_req);
            r_ped_ack     <= w_enter_walk;
        end
    end

`ifdef TLC_NIGHT_FLASH_EN
    // Blink phase of the night-flash yellows
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blink <= 1'b0;
        end else begin
            r_blink <= w_next_blink;
        end
    end
`endif

    // Registered lamp decode of the upcoming phase so lamps move with phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ns_red    <= 1'b1;
            r_ns_yellow <= 1'b0;
            r_ns_green  <= 1'b0;
            r_ew_red    <= 1'b1;
            r_ew_yellow <= 1'b0;
            r_ew_green  <= 1'b0;
            r_walk      <= 1'b0;
        end else begin
            r_ns_red    <= (w_next_phase == c_ew_g) || (w_next_phase == c_ew_y) ||
                           (w_next_phase == c_ar_a) || (w_next_phase == c_ar_b) ||
                           (w_next_phase == c_walk);
            r_ns_yellow <= (w_next_phase == c_ns_y) ||
                           ((w_next_phase == c_flash) && w_blink_lit);
            r_ns_green  <= (w_next_phase == c_ns_g);
            r_ew_red    <= (w_next_phase == c_ns_g) || (w_next_phase == c_ns_y) ||
                           (w_next_phase == c_ar_a) || (w_next_phase == c_ar_b) ||
                           (w_next_phase == c_walk);
            r_ew_yellow <= (w_next_phase == c_ew_y) ||
                           ((w_next_phase == c_flash) && w_blink_lit);
            r_ew_green  <= (w_next_phase == c_ew_g);
            r_walk      <= (w_next_phase == c_walk);
        end
    end

    assign phase     = r_phase;
    assign ped_ack   = r_ped_ack;
    assign ns_red    = r_ns_red;
    assign ns_yellow = r_ns_yellow;
    assign ns_green  = r_ns_green;
    assign ew_red    = r_ew_red;
    assign ew_yellow = r_ew_yellow;
    assign ew_green  = r_ew_green;
    assign walk      = r_walk;

`ifndef SYNTHESIS
    // Safety invariants on the lamp outputs
    a_ns_onehot : assert property (@(posedge clock) disable iff (reset)
        (r_phase != c_flash) |-> $onehot({r_ns_red, r_ns_yellow, r_ns_green}));
    a_ew_onehot : assert property (@(posedge clock) disable iff (reset)
        (r_phase != c_flash) |-> $onehot({r_ew_red, r_ew_yellow, r_ew_green}));
    a_no_dual_green : assert property (@(posedge clock) disable iff (reset)
        !(r_ns_green && r_ew_green));
    a_ns_to_ew_green : assert property (@(posedge clock) disable iff (reset)
        r_ns_green |=> !r_ew_green);
    a_ew_to_ns_green : assert property (@(posedge clock) disable iff (reset)
        r_ew_green |=> !r_ns_green);
    a_walk_reds : assert property (@(posedge clock) disable iff (reset)
        r_walk |-> (r_ns_red && r_ew_red));
`endif

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intersection_phase_scheduler
//  Description : Table-driven bench for intersection_phase_scheduler plus
//                hand-written reset and night-flash sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_phase_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ns_car = 1'b0;
    logic       ew_car = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       walk;
    logic [2:0] phase;
`ifdef TLC_NIGHT_FLASH_EN
    logic       night_flash = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    intersection_phase_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .ns_car    (ns_car),
        .ew_car    (ew_car),
        .ped_req   (ped_req),
`ifdef TLC_NIGHT_FLASH_EN
        .night_flash(night_flash),
`endif
        .ped_ack   (ped_ack),
        .ns_red    (ns_red),
        .ns_yellow (ns_yellow),
        .ns_green  (ns_green),
        .ew_red    (ew_red),
        .ew_yellow (ew_yellow),
        .ew_green  (ew_green),
        .walk      (walk),
        .phase     (phase)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ns;
        logic       ew;
        logic       ped;
        logic [2:0] ph;
        logic       ack;
    } vec_t;

    vec_t vecs[$];

    // Append n identical per-cycle vectors
    function automatic void add_run(int n, logic ns, logic ew, logic ped,
                                    logic [2:0] ph, logic ack);
        vec_t v;
        v.ns = ns; v.ew = ew; v.ped = ped; v.ph = ph; v.ack = ack;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // Expected {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for a non-flash phase
    function automatic logic [6:0] lamps_of(logic [2:0] ph);
        case (ph)
            3'd0: lamps_of = 7'b001_100_0;
            3'd1: lamps_of = 7'b010_100_0;
            3'd2: lamps_of = 7'b100_100_0;
            3'd3: lamps_of = 7'b100_001_0;
            3'd4: lamps_of = 7'b100_010_0;
            3'd5: lamps_of = 7'b100_100_0;
            3'd6: lamps_of = 7'b100_100_1;
            default: lamps_of = 7'b000_000_0;
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] lamps_now();
        return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit found;

        // Cycle-by-cycle expectations from reset release (edge 1 onward)
        add_run(1,  0, 0, 0, 3'd5, 0);   // AR_B remaining cycle
        add_run(13, 0, 0, 0, 3'd0, 0);   // NS_G held with no demand (edges 2..14)
        add_run(3,  1, 1, 0, 3'd0, 0);   // edges 15..17
        add_run(3,  1, 1, 0, 3'd1, 0);   // NS_Y 18..20
        add_run(2,  1, 1, 0, 3'd2, 0);   // AR_A 21..22
        add_run(8,  1, 1, 0, 3'd3, 0);   // EW_G 23..30
        add_run(3,  1, 1, 0, 3'd4, 0);   // EW_Y 31..33
        add_run(2,  1, 1, 0, 3'd5, 0);   // AR_B 34..35
        add_run(8,  1, 1, 0, 3'd0, 0);   // NS_G 36..43
        add_run(3,  1, 1, 0, 3'd1, 0);
        add_run(2,  1, 1, 0, 3'd2, 0);
        add_run(8,  1, 1, 0, 3'd3, 0);   // 49..56
        add_run(3,  1, 1, 0, 3'd4, 0);
        add_run(2,  1, 1, 0, 3'd5, 0);   // 60..61
        add_run(3,  1, 1, 0, 3'd0, 0);   // NS_G cycles 1..3 (62..64)
        add_run(1,  1, 1, 1, 3'd0, 0);   // ped_req during NS_G cycle 3 (edge 65)
        add_run(4,  1, 1, 0, 3'd0, 0);   // 66..69
        add_run(3,  1, 1, 0, 3'd1, 0);   // NS_Y 70..72
        add_run(2,  1, 1, 0, 3'd2, 0);   // AR_A 73..74
        add_run(1,  1, 1, 0, 3'd6, 1);   // WALK cycle 1 with ack (75)
        add_run(2,  1, 1, 0, 3'd6, 0);   // 76..77
        add_run(1,  1, 1, 1, 3'd6, 0);   // ped_req during WALK cycle 3 (78)
        add_run(1,  1, 1, 0, 3'd6, 0);   // 79
        add_run(8,  1, 1, 0, 3'd3, 0);   // EW_G 80..87 (last green was NS)
        add_run(3,  1, 1, 0, 3'd4, 0);   // EW_Y 88..90
        add_run(2,  1, 1, 0, 3'd5, 0);   // AR_B 91..92
        add_run(1,  0, 0, 0, 3'd6, 1);   // second WALK with ack (93)
        add_run(4,  0, 0, 0, 3'd6, 0);   // 94..97
        add_run(12, 0, 0, 0, 3'd0, 0);   // NS_G held (98..109)

        // Reset state
        step();
        chk("reset_phase", phase, 5);
        chk("reset_lamps", lamps_now(), 7'b100_100_0);
        chk("reset_ack", ped_ack, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            ns_car  = vecs[i].ns;
            ew_car  = vecs[i].ew;
            ped_req = vecs[i].ped;
            step();
            chk($sformatf("v%0d_phase", i), phase, vecs[i].ph);
            chk($sformatf("v%0d_lamps", i), lamps_now(), lamps_of(vecs[i].ph));
            chk($sformatf("v%0d_ack", i), ped_ack, vecs[i].ack);
        end
        ped_req = 1'b0;

        // Asynchronous reset during EW_Y cycle 2
        ns_car = 1'b1;
        ew_car = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (phase == 3'd4) found = 1'b1;
        end
        chk("reach_ew_y", found, 1);
        step();
        chk("ew_y_cycle2", phase, 4);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ew_yellow", ew_yellow, 0);
        chk("async_rst_reds", {ns_red, ew_red}, 2'b11);
        chk("async_rst_phase", phase, 5);
        #1 reset = 1'b0;
        ns_car = 1'b0;
        ew_car = 1'b0;
        step();
        chk("post_rst_ar_b1", phase, 5);
        step();
        chk("post_rst_ar_b2", phase, 0);
        chk("post_rst_lamps", lamps_now(), lamps_of(3'd0));

`ifdef TLC_NIGHT_FLASH_EN
        // Night flash: both yellows 3 on / 3 off, exit through AR_B to NS_G
        night_flash = 1'b1;
        ns_car = 1'b1;
        ew_car = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (phase == 3'd7) found = 1'b1;
        end
        chk("reach_flash", found, 1);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            chk($sformatf("flash_c%0d_phase", k), phase, 7);
            chk($sformatf("flash_c%0d_lamps", k), lamps_now(),
                (k <= 3) ? 7'b010_010_0 : 7'b000_000_0);
            if (k == 4) night_flash = 1'b0;
        end
        ns_car = 1'b0;
        ew_car = 1'b0;
        step();
        chk("flash_exit_ar_b1", phase, 5);
        chk("flash_exit_lamps", lamps_now(), 7'b100_100_0);
        step();
        chk("flash_exit_ar_b2", phase, 5);
        step();
        chk("flash_exit_ns_g", phase, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences a two-way intersection: the north-south (NS) and east-west (EW) lamp sets plus a shared pedestrian walk phase.
- Top-level phase controller above the per-lamp drivers. Decides green ownership, timing, all-red clearance and pedestrian service.
- Vehicle-sensor gap logic holds green while the opposing approach is empty. Every hand-off is guaranteed to pass through yellow and then all-red.

Parameters:
- GREEN_TICKS, 8: minimum green duration in cycles (also the hold-extension quantum).
- YELLOW_TICKS, 3: yellow duration in cycles.
- ALLRED_TICKS, 2: all-red clearance duration in cycles.
- WALK_TICKS, 5: pedestrian walk duration in cycles.
- CNT_W, 8: phase timer width. All *_TICKS values must be in 1..2^CNT_W-1.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high; returns the block to its reset state immediately.
- ns_car, input, 1: level; vehicle waiting on NS.
- ew_car, input, 1: level; vehicle waiting on EW.
- ped_req, input, 1: single-cycle request pulse from the push-button conditioner.
- ped_ack, output, 1: single-cycle pulse; request accepted and walk started.
- ns_red / ns_yellow / ns_green, output, 1 each: NS lamps, one-hot.
- ew_red / ew_yellow / ew_green, output, 1 each: EW lamps, one-hot.
- walk, output, 1: pedestrian walk lamp.
- phase, output, 3: current state encoding, for debug and status.

Behaviour:
- One clock; reset is asynchronous and active-high.
- State encoding: NS_G=0, NS_Y=1, AR_A=2 (after NS), EW_G=3, EW_Y=4, AR_B=5 (after EW), WALK=6, FLASH=7 (optional feature only).
- Timer: loaded with DURATION-1 on entry to each state and decremented every cycle. The state is left on the edge where the timer is 0, so each state lasts exactly DURATION cycles.
- Transitions, evaluated only when the timer is 0:
  - NS_G: if ew_car or ped_pending, go to NS_Y. Otherwise stay in NS_G and reload GREEN_TICKS-1.
  - NS_Y: go to AR_A.
  - AR_A: if ped_pending, go to WALK; else go to EW_G.
  - EW_G and EW_Y: mirror NS_G and NS_Y, using ns_car. EW_Y goes to AR_B.
  - AR_B: if ped_pending, go to WALK; else go to NS_G.
  - WALK: go to the green opposite last_green. last_green is set to NS on entering NS_G and to EW on entering EW_G.
- ped_pending: a sticky bit.
  - Set by ped_req in any cycle.
  - Cleared on the edge that enters WALK; ped_ack=1 for that first WALK cycle only.
  - A ped_req in that same cycle is absorbed.
  - A ped_req during later WALK cycles sets pending again; it is served at the next all-red.
- Outputs are registered and update on the same edge as phase:
  - NS_G: ns_green=1, ew_red=1.
  - NS_Y: ns_yellow=1, ew_red=1.
  - EW_G / EW_Y: mirror of NS_G / NS_Y.
  - AR_A, AR_B: both reds=1.
  - WALK: both reds=1, walk=1.
- Safety invariants, checked by assertion:
  - Each lamp set is one-hot.
  - ns_green and ew_green are never both 1.
  - A green is never followed directly by the other direction's green.
  - walk=1 implies both reds=1.
- Reset values:
  - Internal: phase=AR_B, timer=ALLRED_TICKS-1, last_green=EW, ped_pending=0.
  - Outputs: ns_red=ew_red=1, all other lamps 0, walk=0, ped_ack=0.
- Reset asserted mid-operation forces the reset values asynchronously; no yellow is completed.
- Simultaneous ns_car and ew_car: the current green runs its full GREEN_TICKS, then hands off (fair alternation).

Optional Feature:
- Macro: TLC_NIGHT_FLASH_EN.
- When defined:
  - Adds input night_flash (1 bit).
  - In AR_A or AR_B with the timer at 0, night_flash=1 has priority over ped_pending and over green. It enters FLASH.
  - In FLASH, ns_yellow and ew_yellow blink together, toggling every YELLOW_TICKS cycles and starting lit. Red, green and walk are 0.
  - With night_flash=0, FLASH exits to AR_B (timer=ALLRED_TICKS-1) at the next toggle point. ped_pending is retained.
- When undefined: the port is absent and FLASH is unreachable.

Test Plan:
- Reset deasserted, ns_car=ew_car=0 -> both red for 2 edges; ns_green=1 from the 2nd edge onward and holds indefinitely; phase=0.
- ns_car=ew_car=1 steady -> repeating 26-cycle pattern: NS_G 8, NS_Y 3, AR_A 2, EW_G 8, EW_Y 3, AR_B 2; greens never overlap.
- ped_req pulse in NS_G cycle 3, ew_car=1 -> NS_Y 3, AR_A 2, then WALK 5 with ped_ack=1 only in WALK cycle 1, then EW_G.
- ped_req pulse in WALK cycle 3 -> pending stays set; after the next green/yellow/all-red a second WALK occurs with a second ped_ack pulse.
- reset pulsed during EW_Y cycle 2 -> ew_yellow=0 and ns_red=ew_red=1 without a clock edge; resumes with AR_B 2 cycles, then NS_G.
- TLC_NIGHT_FLASH_EN, night_flash=1 during EW_G with cars -> after EW_Y and AR_B, both yellows blink 3 on / 3 off. Dropping night_flash -> AR_B 2 cycles, then NS_G.
